// File: rtl/vga_window_scanner.sv
// vga_window_scanner: VGA raster generator that fetches a scaled image window from a
// synchronous pixel memory and realigns sync, enable and colour behind the read latency.
module vga_window_scanner #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned WIN_X      = 170,
    parameter int unsigned WIN_Y      = 90,
    parameter int unsigned IMG_W      = 300,
    parameter int unsigned IMG_H      = 300,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned BASE_ADDR  = 24,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [23:0] BG_COLOR   = 24'h10A6ED
) (
    input  logic              VGA_CLK_IN,
    input  logic              rst_n,
    input  logic [23:0]       px,
    output logic [ADDR_W-1:0] px_addr,
    output logic              px_rd,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue,
    output logic              o_frame_start,
    output logic              VGA_CLK_OUT
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned WIN_W   = IMG_W << SCALE_LOG2;
    localparam int unsigned WIN_H   = IMG_H << SCALE_LOG2;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
    localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;

    // Replication counters wrap at 2^SCALE_LOG2 - 1; with no scaling they stay at zero.
    localparam logic [1:0]        SUB_MAX = 2'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(IMG_W);

    // Per-pixel control bits carried alongside the memory read.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
        logic fs;
    } ctl_t;

    logic [HW-1:0]     h_q;
    logic [VW-1:0]     v_q;
    logic [31:0]       hc;
    logic [31:0]       vc;

    logic              h_last;
    logic              v_last;
    logic              de_now;
    logic              win_col;
    logic              win_row;
    logic              in_win;
    logic              row_in;
    ctl_t              ctl_now;

    logic [ADDR_W-1:0] col_q;
    logic [1:0]        subx_q;
    logic [ADDR_W-1:0] line_base_q;
    logic [1:0]        suby_q;

    ctl_t [RD_LATENCY-1:0] pipe_q;
    ctl_t                  tail;

    assign hc          = 32'(h_q);
    assign vc          = 32'(v_q);
    assign tail        = pipe_q[RD_LATENCY-1];
    assign VGA_CLK_OUT = VGA_CLK_IN;

    // Decode the raster position into region flags for the current pixel.
    always_comb begin
        h_last     = (hc == H_TOTAL - 1);
        v_last     = (vc == V_TOTAL - 1);
        de_now     = (hc < H_ACTIVE) && (vc < V_ACTIVE);
        win_col    = (hc >= WIN_X) && (hc < WIN_X + WIN_W);
        win_row    = (vc >= WIN_Y) && (vc < WIN_Y + WIN_H);
        // Clipping to the active area keeps fetches out of the porches.
        in_win     = de_now && win_col && win_row;
        row_in     = (vc < V_ACTIVE) && win_row;
        ctl_now.hs  = (hc >= HS_LO) && (hc < HS_HI);
        ctl_now.vs  = (vc >= VS_LO) && (vc < VS_HI);
        ctl_now.de  = de_now;
        ctl_now.win = in_win;
        ctl_now.fs  = (hc == 0) && (vc == 0);
    end

    // Horizontal and vertical raster counters; v steps only when h wraps.
    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_last) begin
            h_q <= '0;
            v_q <= v_last ? '0 : v_q + VW'(1);
        end else begin
            h_q <= h_q + HW'(1);
        end
    end

    // Source column: advances every 2^SCALE_LOG2 window clocks, cleared outside the window.
    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            subx_q <= '0;
        end else if (in_win) begin
            if (subx_q == SUB_MAX) begin
                subx_q <= '0;
                col_q  <= col_q + ADDR_W'(1);
            end else begin
                subx_q <= subx_q + 2'd1;
            end
        end else begin
            col_q  <= '0;
            subx_q <= '0;
        end
    end

    // Line base: gains one image row every 2^SCALE_LOG2 window lines, restarts each frame.
    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            line_base_q <= BASE;
            suby_q      <= '0;
        end else if (h_last) begin
            if (v_last) begin
                line_base_q <= BASE;
                suby_q      <= '0;
            end else if (row_in) begin
                if (suby_q == SUB_MAX) begin
                    suby_q      <= '0;
                    line_base_q <= line_base_q + STRIDE;
                end else begin
                    suby_q <= suby_q + 2'd1;
                end
            end
        end
    end

    // Read request: address registers only for window pixels, otherwise it holds.
    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            px_addr <= BASE;
            px_rd   <= 1'b0;
        end else if (in_win) begin
            px_addr <= line_base_q + col_q;
            px_rd   <= 1'b1;
        end else begin
            px_rd   <= 1'b0;
        end
    end

    // Control delay line matching the address register plus the memory read latency.
    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= ctl_now;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Output stage: colour is picked at the same edge that px is sampled.
    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            o_hsync                   <= ~HS_POL;
            o_vsync                   <= ~VS_POL;
            o_de                      <= 1'b0;
            o_frame_start             <= 1'b0;
            {o_red, o_green, o_blue}  <= 24'h000000;
        end else begin
            o_hsync       <= tail.hs ? HS_POL : ~HS_POL;
            o_vsync       <= tail.vs ? VS_POL : ~VS_POL;
            o_de          <= tail.de;
            o_frame_start <= tail.fs;
            if (tail.win) begin
                {o_red, o_green, o_blue} <= px;
            end else if (tail.de) begin
                {o_red, o_green, o_blue} <= BG_COLOR;
            end else begin
                {o_red, o_green, o_blue} <= 24'h000000;
            end
        end
    end

endmodule

// File: tb/tb_vga_window_scanner.sv
// Bench for vga_window_scanner: two small-raster instances compared every cycle against a
// position-based pixel model, plus literal trace checks and random mid-frame resets.
module tb_vga_window_scanner;

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
        int hpol, vpol, wx, wy, iw, ih, s, base, rdl;
    } cfg_t;

    typedef struct {
        bit de, hs, vs, win, fs;
        int addr;
        int color;
    } pix_t;

    localparam int TR = 2048;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    int          edges;
    bit          chk_en;
    bit          rec_en;
    int          last_a;
    int          last_b;
    cfg_t        ca;
    cfg_t        cb;

    logic [31:0] a_addr, b_addr;
    logic [23:0] a_px, b_px;
    logic        a_rd, a_hs, a_vs, a_de, a_fs, a_clk_out;
    logic        b_rd, b_hs, b_vs, b_de, b_fs, b_clk_out;
    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic [31:0] b_dl [0:1];

    logic        a_hs_t [TR];
    logic        a_vs_t [TR];
    logic        a_fs_t [TR];
    logic        a_de_t [TR];
    logic        a_rd_t [TR];
    logic [31:0] a_ad_t [TR];
    logic [23:0] a_col_t [TR];
    logic        b_hs_t [TR];
    logic        b_fs_t [TR];
    logic        b_de_t [TR];
    logic        b_rd_t [TR];
    logic [31:0] b_ad_t [TR];
    logic [23:0] b_col_t [TR];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: exact right-edge window, vertically clipped, no scaling, latency 1.
    vga_window_scanner #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .WIN_X(3), .WIN_Y(2), .IMG_W(5), .IMG_H(4),
        .SCALE_LOG2(0), .BASE_ADDR(24), .ADDR_W(32), .RD_LATENCY(1), .BG_COLOR(24'h10A6ED)
    ) u_a (
        .VGA_CLK_IN(clk), .rst_n(rst_n), .px(a_px), .px_addr(a_addr), .px_rd(a_rd),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_red(a_r), .o_green(a_g),
        .o_blue(a_b), .o_frame_start(a_fs), .VGA_CLK_OUT(a_clk_out)
    );

    // B: 2x scaling at the origin, latency 3, positive syncs.
    vga_window_scanner #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .WIN_X(0), .WIN_Y(0), .IMG_W(4), .IMG_H(2),
        .SCALE_LOG2(1), .BASE_ADDR(24), .ADDR_W(32), .RD_LATENCY(3), .BG_COLOR(24'h10A6ED)
    ) u_b (
        .VGA_CLK_IN(clk), .rst_n(rst_n), .px(b_px), .px_addr(b_addr), .px_rd(b_rd),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_red(b_r), .o_green(b_g),
        .o_blue(b_b), .o_frame_start(b_fs), .VGA_CLK_OUT(b_clk_out)
    );

    // Memories return px = addr[23:0], sampled by the DUT RD_LATENCY edges after px_addr.
    assign a_px = a_addr[23:0];
    assign b_px = b_dl[1][23:0];

    always @(posedge clk) begin
        b_dl[0] <= b_addr;
        b_dl[1] <= b_dl[0];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the pins must show for raster position pos (0 = pixel (0,0) of a frame).
    function automatic pix_t model_pix(input cfg_t c, input int pos);
        pix_t r;
        int ht, vt, h, v;
        ht = c.ha + c.hfp + c.hsy + c.hbp;
        vt = c.va + c.vfp + c.vsy + c.vbp;
        h = pos % ht;
        v = (pos / ht) % vt;
        r.de  = (h < c.ha) && (v < c.va);
        r.hs  = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsy);
        r.vs  = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsy);
        r.fs  = (h == 0) && (v == 0);
        r.win = r.de && (h >= c.wx) && (h < c.wx + (c.iw << c.s))
                && (v >= c.wy) && (v < c.wy + (c.ih << c.s));
        r.addr  = 0;
        r.color = 0;
        if (r.win) begin
            r.addr  = c.base + ((v - c.wy) / (1 << c.s)) * c.iw + (h - c.wx) / (1 << c.s);
            r.color = r.addr & 'hFFFFFF;
        end else if (r.de) begin
            r.color = 'h10A6ED;
        end
        return r;
    endfunction

    // ev = clock edges since reset release; 0 means in/just out of reset.
    task automatic check_one(input string tag, input cfg_t c, input int ev, inout int last,
                             input logic [31:0] addr, input logic rd, input logic hs,
                             input logic vs, input logic de, input logic [23:0] col,
                             input logic fs);
        pix_t pa;
        pix_t po;
        int   exp_rd;
        exp_rd = 0;
        if (ev >= 1) begin
            pa = model_pix(c, ev - 1);
            if (pa.win) begin
                exp_rd = 1;
                last   = pa.addr;
            end
        end
        chk({tag, ".px_rd"}, 32'(rd), exp_rd);
        chk({tag, ".px_addr"}, addr, last);
        if (ev >= c.rdl + 1) begin
            po = model_pix(c, ev - c.rdl - 1);
        end else begin
            po.de = 0; po.hs = 0; po.vs = 0; po.fs = 0; po.win = 0;
            po.addr = 0; po.color = 0;
        end
        chk({tag, ".hsync"}, 32'(hs), po.hs ? c.hpol : 1 - c.hpol);
        chk({tag, ".vsync"}, 32'(vs), po.vs ? c.vpol : 1 - c.vpol);
        chk({tag, ".de"}, 32'(de), 32'(po.de));
        chk({tag, ".color"}, 32'(col), po.color);
        chk({tag, ".frame_start"}, 32'(fs), 32'(po.fs));
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (!rst_n) begin
                    last_a = ca.base;
                    last_b = cb.base;
                end
                check_one("A", ca, edges, last_a, a_addr, a_rd, a_hs, a_vs, a_de,
                          {a_r, a_g, a_b}, a_fs);
                check_one("B", cb, edges, last_b, b_addr, b_rd, b_hs, b_vs, b_de,
                          {b_r, b_g, b_b}, b_fs);
                if (rst_n && rec_en && edges < TR) begin
                    a_hs_t[edges] = a_hs;  a_vs_t[edges] = a_vs;  a_fs_t[edges] = a_fs;
                    a_de_t[edges] = a_de;  a_rd_t[edges] = a_rd;  a_ad_t[edges] = a_addr;
                    a_col_t[edges] = {a_r, a_g, a_b};
                    b_hs_t[edges] = b_hs;  b_fs_t[edges] = b_fs;  b_de_t[edges] = b_de;
                    b_rd_t[edges] = b_rd;  b_ad_t[edges] = b_addr;
                    b_col_t[edges] = {b_r, b_g, b_b};
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int cnt, f1, f2, k1, k2, first_ad, last_ad, last_e, idx, afs, bfs;
        int exp_l0 [8];
        exp_l0 = '{24, 24, 25, 25, 26, 26, 27, 27};
        ca = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 3, 2, 5, 4, 0, 24, 1};
        cb = '{16, 2, 3, 2, 10, 1, 2, 1, 1, 1, 0, 0, 4, 2, 1, 24, 3};
        checks   = 0;
        failures = 0;
        last_a   = 24;
        last_b   = 24;
        rec_en   = 1'b0;
        chk_en   = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rec_en = 1'b1;
        repeat (700) @(negedge clk);
        rec_en = 1'b0;

        // A: 15-clock line, 120-clock frame, 3 hsync clocks per line, 2 vsync lines.
        cnt = 0;
        for (int k = 2; k <= 16; k++) if (a_hs_t[k] === 1'b0) cnt++;
        chk("A.hsync_clocks_per_line", cnt, 3);
        k1 = -1; k2 = -1;
        for (int k = 3; k < 300; k++) begin
            if (a_hs_t[k] === 1'b0 && a_hs_t[k-1] === 1'b1) begin
                if (k1 < 0) k1 = k;
                else if (k2 < 0) k2 = k;
            end
        end
        chk("A.line_period", k2 - k1, 15);
        f1 = -1; f2 = -1;
        for (int k = 1; k < 690; k++) begin
            if (a_fs_t[k] === 1'b1) begin
                if (f1 < 0) f1 = k;
                else if (f2 < 0) f2 = k;
            end
        end
        chk("A.first_frame_start", f1, 2);
        chk("A.frame_period", f2 - f1, 120);
        cnt = 0;
        for (int k = 2; k <= 121; k++) if (a_vs_t[k] === 1'b0) cnt++;
        chk("A.vsync_clocks_per_frame", cnt, 30);
        cnt = 0; first_ad = -1; last_ad = -1; last_e = -1;
        for (int k = 1; k <= 120; k++) begin
            if (a_rd_t[k] === 1'b1) begin
                cnt++;
                if (first_ad < 0) first_ad = a_ad_t[k];
                last_ad = a_ad_t[k];
                last_e  = k;
            end
        end
        chk("A.first_read_addr", first_ad, 24);
        chk("A.last_read_addr", last_ad, 33);
        chk("A.reads_per_frame", cnt, 10);
        chk("A.last_read_edge", last_e, 53);
        chk("A.background_color", 32'(a_col_t[2]), 32'h10A6ED);
        chk("A.first_window_color", 32'(a_col_t[35]), 24);
        chk("A.porch_color", 32'(a_col_t[10]), 0);
        chk("A.porch_de", 32'(a_de_t[10]), 0);

        // B: replicated addresses on lines 0-1, next source row from line 2.
        idx = 0;
        for (int k = 1; k <= 23; k++) begin
            if (b_rd_t[k] === 1'b1) begin
                if (idx < 8) chk("B.line0_addr", b_ad_t[k], exp_l0[idx]);
                idx++;
            end
        end
        chk("B.line0_reads", idx, 8);
        idx = 0;
        for (int k = 24; k <= 46; k++) begin
            if (b_rd_t[k] === 1'b1) begin
                if (idx < 8) chk("B.line1_addr", b_ad_t[k], exp_l0[idx]);
                idx++;
            end
        end
        chk("B.line1_reads", idx, 8);
        chk("B.line2_rd", 32'(b_rd_t[47]), 1);
        chk("B.line2_addr", b_ad_t[47], 28);
        chk("B.line3_addr", b_ad_t[70], 28);
        k1 = -1; k2 = -1; f1 = -1;
        for (int k = 0; k < 100; k++) begin
            if (b_de_t[k] === 1'b1 && k1 < 0) k1 = k;
            if (b_hs_t[k] === 1'b1 && k2 < 0) k2 = k;
            if (b_fs_t[k] === 1'b1 && f1 < 0) f1 = k;
        end
        chk("B.de_rise_edge", k1, 4);
        chk("B.hsync_first_edge", k2, 22);
        chk("B.frame_start_edge", f1, 4);
        chk("B.first_window_color", 32'(b_col_t[4]), 24);
        chk("B.second_col_color", 32'(b_col_t[6]), 25);

        // Random mid-frame resets: immediate reset values, clean restart.
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(60, 400)) @(negedge clk);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            last_a = ca.base;
            last_b = cb.base;
            check_one("A.async_rst", ca, 0, last_a, a_addr, a_rd, a_hs, a_vs, a_de,
                      {a_r, a_g, a_b}, a_fs);
            check_one("B.async_rst", cb, 0, last_b, b_addr, b_rd, b_hs, b_vs, b_de,
                      {b_r, b_g, b_b}, b_fs);
            chk("A.clk_out", 32'(a_clk_out), 32'(clk));
            chk("B.clk_out", 32'(b_clk_out), 32'(clk));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
            afs = -1;
            bfs = -1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (a_fs === 1'b1 && afs < 0) afs = edges;
                if (b_fs === 1'b1 && bfs < 0) bfs = edges;
                if (edges == 1) chk("B.restart_addr", b_addr, 24);
            end
            chk("A.frame_start_after_reset", afs, 2);
            chk("B.frame_start_after_reset", bfs, 4);
        end

        repeat (200) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
